// File: rtl/ql_irq_ctrl.sv
// ql_irq_ctrl - QL peripheral interrupt controller (up to 8 sources).
//
// Each source is synchronised, edge-detected with a per-source polarity,
// and latched into a pending bit under a mask. The CPU reads and acks pending
// bits, can set them from software, and can read the lowest pending index.
// Internal and external (IPC) levels merge onto the 68008 active-low IPL lines.
//
// Optional feature: define IRQ_OVERRUN_EN for per-source overrun flags and a
// saturating overrun counter on register 2. If it is undefined, register 2
// reads 0.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   cen        bus clock enable, gates register writes
//   src        raw asynchronous interrupt sources [NUM_SRC-1:0]
//   ext_ipl_n  external IPL request (IPC), active low
//   ipl_n      merged IPL to CPU, active low, registered
//   irq        OR of pending bits
//   cpu_sel    register block selected
//   cpu_wr     write strobe
//   cpu_addr   register index
//   cpu_ds     data strobes, active low ([1]=upper byte, [0]=lower byte)
//   cpu_din    write data
//   cpu_dout   read data, combinational from cpu_addr
//
// Register map:
//   0  R: {mask, pending}      W: hi -> mask, lo -> write-1-to-clear pending
//   1  R: {pol, synced src}    W: hi -> pol (lo ignored)
//   2  R: {ovr_cnt, ovr}       W: any write clears ovr_cnt (IRQ_OVERRUN_EN)
//   3  R: {any, 12'b0, vec}    W: lo -> write-1-to-set pending (mask ignored)
module ql_irq_ctrl #(
    parameter int NUM_SRC     = 5,
    parameter int IRQ_LEVEL   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cen,
    input  logic [NUM_SRC-1:0] src,
    input  logic [2:0]         ext_ipl_n,
    output logic [2:0]         ipl_n,
    output logic               irq,
    input  logic               cpu_sel,
    input  logic               cpu_wr,
    input  logic [1:0]         cpu_addr,
    input  logic [1:0]         cpu_ds,
    input  logic [15:0]        cpu_din,
    output logic [15:0]        cpu_dout
);

    localparam logic [7:0] VALID = 8'((1 << NUM_SRC) - 1);

    logic [SYNC_STAGES*NUM_SRC-1:0] sync_chain;
    logic [NUM_SRC-1:0]             s, h, edge_q;
    logic [7:0]                     edge_w;
    logic [7:0]                     mask, pol, pending;
    logic [7:0]                     ack, sw_set, set_edge;
    logic                           wr_en, wr_lo, wr_hi;
    logic [2:0]                     vec;
    logic [2:0]                     ext_lvl, int_lvl, lvl;
    logic [15:0]                    rd_ovr;

    // Synchroniser chain, newest sample in the low slice.
    if (SYNC_STAGES == 1) begin : g_sync1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_chain <= '0;
            else       sync_chain <= src;
        end
    end else begin : g_syncn
        always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_chain <= '0;
            else       sync_chain <= {sync_chain[(SYNC_STAGES-1)*NUM_SRC-1:0], src};
        end
    end

    assign s = sync_chain[SYNC_STAGES*NUM_SRC-1 -: NUM_SRC];

    // Edges are registered before they reach the pending logic, giving a fixed
    // SYNC_STAGES+1 clock path from first sample to pending. An edge needs s to
    // change, so rewriting pol alone never fires one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h      <= '0;
            edge_q <= '0;
        end else begin
            h      <= s;
            edge_q <= (s ^ h) & (s ^ pol[NUM_SRC-1:0]);
        end
    end

    assign edge_w   = 8'(edge_q);
    assign set_edge = edge_w & mask;

    assign wr_en  = cen & cpu_sel & cpu_wr;
    assign wr_lo  = wr_en & ~cpu_ds[0];
    assign wr_hi  = wr_en & ~cpu_ds[1];
    assign ack    = (wr_lo && cpu_addr == 2'd0) ? cpu_din[7:0] : '0;
    assign sw_set = (wr_lo && cpu_addr == 2'd3) ? (cpu_din[7:0] & VALID) : '0;

    // Sets are ORed in after the ack so a same-clock set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask    <= '0;
            pol     <= '0;
            pending <= '0;
        end else begin
            pending <= ((pending & ~ack) | set_edge | sw_set) & VALID;
            if (wr_hi && cpu_addr == 2'd0) mask <= cpu_din[15:8] & VALID;
            if (wr_hi && cpu_addr == 2'd1) pol  <= cpu_din[15:8] & VALID;
        end
    end

    assign irq = |pending;

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        vec = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending[7 - i]) vec = 3'(7 - i);
        end
    end

    assign ext_lvl = ~ext_ipl_n;
    assign int_lvl = irq ? 3'(IRQ_LEVEL) : 3'd0;
    assign lvl     = (ext_lvl > int_lvl) ? ext_lvl : int_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ipl_n <= 3'b111;
        else       ipl_n <= ~lvl;
    end

`ifdef IRQ_OVERRUN_EN
    logic [7:0] ovr, ovr_cnt, ovr_set;

    assign ovr_set = set_edge & pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr     <= '0;
            ovr_cnt <= '0;
        end else begin
            ovr <= ((ovr & ~ack) | ovr_set) & VALID;
            if (wr_en && cpu_addr == 2'd2)
                ovr_cnt <= '0;
            else if ((|ovr_set) && ovr_cnt != 8'hFF)
                ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

    assign rd_ovr = {ovr_cnt, ovr};
`else
    assign rd_ovr = 16'h0000;
`endif

    always_comb begin
        cpu_dout = '0;
        case (cpu_addr)
            2'd0: cpu_dout = {mask, pending};
            2'd1: cpu_dout = {pol, 8'(s)};
            2'd2: cpu_dout = rd_ovr;
            2'd3: cpu_dout = irq ? {1'b1, 12'b0, vec} : 16'h0000;
            default: cpu_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_ql_irq_ctrl.sv
module tb_ql_irq_ctrl;

    localparam int NUM_SRC     = 5;
    localparam int IRQ_LEVEL   = 2;
    localparam int SYNC_STAGES = 2;
    localparam logic [7:0] VM  = 8'h1F;

    logic               clk = 1'b0;
    logic               reset;
    logic               cen;
    logic [NUM_SRC-1:0] src;
    logic [2:0]         ext_ipl_n;
    logic [2:0]         ipl_n;
    logic               irq;
    logic               cpu_sel;
    logic               cpu_wr;
    logic [1:0]         cpu_addr;
    logic [1:0]         cpu_ds;
    logic [15:0]        cpu_din;
    logic [15:0]        cpu_dout;

    ql_irq_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .IRQ_LEVEL  (IRQ_LEVEL),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cen      (cen),
        .src      (src),
        .ext_ipl_n(ext_ipl_n),
        .ipl_n    (ipl_n),
        .irq      (irq),
        .cpu_sel  (cpu_sel),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_ds   (cpu_ds),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] dout;
        logic        irq;
        logic [2:0]  ipl;
    } chk_t;

    chk_t sb[$];
    chk_t e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic chk_req = 1'b0;

    // Reference state: what the register file should hold.
    logic [7:0] m_mask, m_pol, m_pend, m_ovr, m_cnt;
    logic [2:0] m_ext;

    // Monitor: compares the DUT against the oldest expectation.
    always @(negedge clk) begin
        if (chk_req) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: no expected entry queued");
            end else begin
                e = sb.pop_front();
                n_chk++;
                if (cpu_dout !== e.dout) begin
                    n_fail++;
                    $display("FAIL %s dout: got %h want %h", e.name, cpu_dout, e.dout);
                end
                n_chk++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: got %b want %b", e.name, irq, e.irq);
                end
                n_chk++;
                if (ipl_n !== e.ipl) begin
                    n_fail++;
                    $display("FAIL %s ipl_n: got %b want %b", e.name, ipl_n, e.ipl);
                end
            end
        end
    end

    function automatic logic [2:0] exp_ipl();
        logic [2:0] el, il;
        el = ~m_ext;
        il = (m_pend != 0) ? 3'(IRQ_LEVEL) : 3'd0;
        return ~((el > il) ? el : il);
    endfunction

    function automatic logic [15:0] exp_a3();
        logic [2:0] v;
        v = 3'd0;
        for (int i = 7; i >= 0; i--) if (m_pend[i]) v = 3'(i);
        return (m_pend != 0) ? {1'b1, 12'b0, v} : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_a2();
`ifdef IRQ_OVERRUN_EN
        return {m_cnt, m_ovr};
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string name, input logic [1:0] a, input logic [15:0] d,
                         input logic i, input logic [2:0] p);
        chk_t c;
        c.name = name; c.dout = d; c.irq = i; c.ipl = p;
        cpu_addr = a;
        sb.push_back(c);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic check_all(input string name);
        check({name, "/a0"}, 2'd0, {m_mask, m_pend}, m_pend != 0, exp_ipl());
        check({name, "/a1"}, 2'd1, {m_pol, 8'(src)}, m_pend != 0, exp_ipl());
        check({name, "/a2"}, 2'd2, exp_a2(),         m_pend != 0, exp_ipl());
        check({name, "/a3"}, 2'd3, exp_a3(),         m_pend != 0, exp_ipl());
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] ds, input logic [15:0] d,
                      input logic c);
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_ds = ds; cpu_din = d; cen = c;
        @(posedge clk);
        #1;
        cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_ds = 2'b11; cen = 1'b1;
    endtask

    // Register-level meaning of a CPU write.
    task automatic m_wr(input logic [1:0] a, input logic [1:0] ds, input logic [15:0] d);
        if (!ds[0]) begin
            if (a == 2'd0) begin
                m_pend = m_pend & ~d[7:0];
                m_ovr  = m_ovr & ~d[7:0];
            end
            if (a == 2'd3) m_pend = m_pend | (d[7:0] & VM);
        end
        if (!ds[1]) begin
            if (a == 2'd0) m_mask = d[15:8] & VM;
            if (a == 2'd1) m_pol  = d[15:8] & VM;
        end
        if (a == 2'd2) m_cnt = 8'h00;
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [1:0] ds, input logic [15:0] d);
        m_wr(a, ds, d);
        wr(a, ds, d, 1'b1);
    endtask

    task automatic wr_s(input logic [1:0] a, input logic [1:0] ds, input logic [15:0] d);
        do_wr(a, ds, d);
        settle(2);
    endtask

    // A source level change is an event: it counts if it moves away from pol.
    task automatic m_edge(input logic [NUM_SRC-1:0] ns);
        logic any;
        any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ns[i] != src[i] && (ns[i] != m_pol[i]) && m_mask[i]) begin
                if (m_pend[i]) begin
                    m_ovr[i] = 1'b1;
                    any = 1'b1;
                end else begin
                    m_pend[i] = 1'b1;
                end
            end
        end
        if (any && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic set_src(input logic [NUM_SRC-1:0] ns, input int n);
        m_edge(ns);
        src = ns;
        settle(n);
    endtask

    task automatic m_clear();
        m_mask = '0; m_pol = '0; m_pend = '0; m_ovr = '0; m_cnt = '0;
    endtask

    initial begin
        reset = 1'b1; cen = 1'b1; src = '0; ext_ipl_n = 3'b111;
        cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_ds = 2'b11; cpu_din = '0;
        m_clear();
        m_ext = 3'b111;

        repeat (2) @(posedge clk);
        #1 check("in_reset", 2'd0, 16'h0000, 1'b0, 3'b111);
        @(posedge clk);
        #1 reset = 1'b0;
        settle(1);
        check_all("reset");

        // Rising edge on src[3]: pending three clocks after first sample.
        wr_s(2'd0, 2'b01, 16'h1F00);
        m_edge(5'b01000);
        src = 5'b01000;
        repeat (3) @(posedge clk);
        #1 check("lat_k2", 2'd0, 16'h1F00, 1'b0, 3'b111);
        @(posedge clk);
        #1 check("lat_k3", 2'd0, 16'h1F08, 1'b1, 3'b111);
        @(posedge clk);
        #1 check("lat_k4", 2'd0, 16'h1F08, 1'b1, 3'b101);
        check("vec3", 2'd3, 16'h8003, 1'b1, 3'b101);

        // Two pending, acked one at a time.
        set_src(5'b01010, 6);
        check_all("two_pend");
        wr_s(2'd0, 2'b10, 16'h0002);
        check_all("ack_b1");
        do_wr(2'd0, 2'b10, 16'h0008);
        check("ack_ipl_hold", 2'd0, 16'h1F00, 1'b0, 3'b101);
        @(posedge clk);
        #1 check("ack_ipl_rel", 2'd0, 16'h1F00, 1'b0, 3'b111);

        // Falling-edge polarity on src[0].
        wr_s(2'd1, 2'b01, 16'h0100);
        wr_s(2'd0, 2'b01, 16'h0100);
        set_src(5'b01011, 6);
        check_all("pol_rise");
        set_src(5'b01010, 6);
        check_all("pol_fall");
        wr_s(2'd0, 2'b10, 16'h0001);
        wr_s(2'd1, 2'b01, 16'h0000);
        check_all("pol_tog0");
        wr_s(2'd1, 2'b01, 16'h0100);
        check_all("pol_tog1");

        // Ack of bit 2 in the same clock as the src[2] edge reaches pending.
        wr_s(2'd1, 2'b01, 16'h0000);
        wr_s(2'd0, 2'b01, 16'h1F00);
        m_wr(2'd0, 2'b10, 16'h0004);
        m_edge(5'b01110);
        src = 5'b01110;
        repeat (3) @(posedge clk);
        #1 wr(2'd0, 2'b10, 16'h0004, 1'b1);
        settle(4);
        check_all("ack_vs_set");
        m_ext = 3'b000; ext_ipl_n = 3'b000;
        settle(2);
        check_all("ext_ipl7");
        m_ext = 3'b111; ext_ipl_n = 3'b111;

        // Masked edges discarded; software set ignores the mask.
        wr_s(2'd0, 2'b10, 16'h00FF);
        wr_s(2'd0, 2'b01, 16'h0000);
        set_src(~src, 6);
        check_all("masked");
        wr_s(2'd3, 2'b10, 16'h0010);
        check_all("sw_set");
        wr_s(2'd0, 2'b10, 16'h00FF);

        // Overrun on src[0].
        wr_s(2'd0, 2'b01, 16'h0100);
        set_src(src & ~NUM_SRC'(1), 4);
        set_src(src | NUM_SRC'(1), 4);
        for (int k = 0; k < 3; k++) begin
            set_src(src & ~NUM_SRC'(1), 4);
            set_src(src | NUM_SRC'(1), 4);
        end
        check_all("ovr3");
        wr_s(2'd0, 2'b10, 16'h0001);
        check_all("ovr_ack");
        wr_s(2'd2, 2'b00, 16'h0000);
        check_all("ovr_clr");
        set_src(src & ~NUM_SRC'(1), 2);
        set_src(src | NUM_SRC'(1), 2);
        for (int k = 0; k < 300; k++) begin
            set_src(src & ~NUM_SRC'(1), 2);
            set_src(src | NUM_SRC'(1), 2);
        end
        settle(6);
        check_all("ovr_sat");

        // Randomised mix of source activity and register traffic.
        for (int it = 0; it < 80; it++) begin
            logic [15:0] d;
            logic [1:0]  ds;
            d  = 16'($urandom);
            ds = 2'($urandom);
            case ($urandom_range(0, 7))
                0, 1: set_src(src ^ NUM_SRC'($urandom), 6);
                2: wr_s(2'd0, ds, d);
                3: wr_s(2'd1, ds, d);
                4: wr_s(2'd3, ds, d);
                5: begin
                    wr(2'($urandom), ds, d, 1'b0);
                    settle(2);
                end
                6: wr_s(2'd2, 2'b00, d);
                default: begin
                    m_ext = 3'($urandom);
                    ext_ipl_n = m_ext;
                    settle(2);
                end
            endcase
            check_all($sformatf("rnd%0d", it));
        end

        // Reset while an edge is in the synchroniser.
        m_ext = 3'b111; ext_ipl_n = 3'b111;
        wr_s(2'd0, 2'b01, 16'h1F00);
        wr_s(2'd1, 2'b01, 16'h0000);
        src = ~src;
        @(posedge clk);
        #1 reset = 1'b1;
        m_clear();
        #1 check("mid_reset", 2'd0, 16'h0000, 1'b0, 3'b111);
        #2 reset = 1'b0;
        settle(6);
        check_all("post_reset");

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ql_irq_ctrl.md
Name: ql_irq_ctrl

Overview:
- Parametrised successor to the QL peripheral interrupt logic: up to 8 interrupt sources, fully synchronous to clk.
- Sources are synchronised and edge-detected with per-source polarity, then latched into pending bits under a mask.
- Pending bits are acknowledged by the CPU; a software-set path and a priority vector register are provided.
- Internal and external (IPC) interrupt levels are merged onto the 68008 active-low IPL lines.

Parameters:
NUM_SRC, 5, number of interrupt sources (1..8); unused register bits read 0.
IRQ_LEVEL, 2, 68k level driven while any pending bit is set (1..7).
SYNC_STAGES, 2, synchroniser depth on src inputs (1..3).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
cen  in  1  bus clock enable; register writes only when high
src  in  NUM_SRC  raw interrupt sources (vsync, gap, xint, ...), asynchronous
ext_ipl_n  in  3  external IPL request (IPC), active low
ipl_n  out  3  merged IPL to CPU, active low, registered
irq  out  1  OR of pending bits
cpu_sel  in  1  register block selected
cpu_wr  in  1  write strobe
cpu_addr  in  2  register index
cpu_ds  in  2  data strobes, active low; [1]=upper byte, [0]=lower byte
cpu_din  in  16  write data
cpu_dout  out  16  read data, combinational from cpu_addr

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. Reset clears all registers and synchronisers; ipl_n=3'b111, irq=0, cpu_dout reflects zeroed registers.
- Sync: each src bit passes through SYNC_STAGES flops (s), plus one history flop (h).
- Edge: edge[i] = (s[i]!=h[i]) && (s[i]^pol[i]); pol=0 rising, pol=1 falling. Changing pol never creates an edge.
- Set: pending[i] is set on edge[i] && mask[i]. Edges on masked sources are discarded.
- Latency: a src change first sampled at edge k sets pending at edge k+SYNC_STAGES+1; ipl_n changes one clk later; irq is combinational from pending.
- IPL: lvl = max(~ext_ipl_n, irq ? IRQ_LEVEL : 0); ipl_n <= ~lvl each clk, with no cen gating.
- Writes: occur when cen && cpu_sel && cpu_wr; byte lanes are gated by cpu_ds.
  - addr 0, lower byte: write-1-to-clear pending[7:0].
  - addr 0, upper byte: mask <= din[15:8].
  - addr 1, upper byte: pol <= din[15:8]. The lower byte is ignored.
  - addr 3, lower byte: write-1-to-set pending, independent of mask.
- Reads:
  - addr 0: {mask, pending}.
  - addr 1: {pol, s}.
  - addr 2: see Optional Feature.
  - addr 3: {any, 12'b0, vec[2:0]}, where vec = index of the lowest-numbered set pending bit and any=irq. Reads 0 when none pending.
- Priority: within one clk, set (edge or software) beats ack on the same bit, so the bit stays 1. Ack of bit i never affects bit j.
- Mask cleared while a bit is pending: the bit stays pending until acked.
- Widths: bits >= NUM_SRC of mask/pol/pending are tied 0 and read 0.
- Reset mid-operation: all state clears immediately; edges already in the synchroniser are lost.

Optional Feature:
- Macro: IRQ_OVERRUN_EN.
- Defined:
  - Per-source sticky ovr[i] sets when edge[i] && mask[i] && pending[i] already set. It clears when pending[i] is acked.
  - ovr_cnt is an 8-bit saturating count (stops at 255) of all overrun events in one cycle, counting one per clk regardless of how many sources overrun.
  - Read addr 2 = {ovr_cnt, ovr}; any write to addr 2 clears ovr_cnt.
- Undefined: addr 2 reads 16'h0000, writes are ignored, and no counter logic is synthesised.

Test Plan:
- Reset, then mask=8'h1F; rising edge on src[3] -> pending=8'h08 after 3 clks (SYNC_STAGES=2), irq=1, ipl_n=3'b101 one clk later; addr 3 reads 16'h8003.
- src[1] and src[3] pending; write addr 0 lower 8'h02 -> pending=8'h08, vec=3; write 8'h08 -> pending=0, ipl_n=3'b111 next clk.
- pol=8'h01, mask=8'h01: src[0] rising -> no pending; falling -> pending[0]=1; toggling pol with src static -> no new pending.
- Ack of bit 2 in the same clk as an edge on src[2] -> pending[2] remains 1; ext_ipl_n=3'b000 with pending set -> ipl_n=3'b000.
- mask=0, edges on all src -> pending=0; write addr 3 8'h10 -> pending=8'h10 and irq=1.
- IRQ_OVERRUN_EN: three further src[0] edges while pending[0]=1 -> addr 2 reads 16'h0301; ack bit 0 -> 16'h0300; write addr 2 -> 16'h0000; after 300 overruns ovr_cnt=8'hFF.
